// File: rtl/haz_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   fwd_sel_t    : operand source select for the decode-stage forwarding muxes
//   XZR, LR      : zero register (never forwarded or stalled on) and BL link register
//   stage_info_t : shadow copy of the destination/control bits held for EX and MEM
package haz_pkg;

  localparam int unsigned RegW = 5;

  localparam logic [RegW-1:0] XZR = 5'd31;
  localparam logic [RegW-1:0] LR  = 5'd30;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic [RegW-1:0] dest;
    logic            reg_write;
    logic            mem_read;
    logic            update_flags;
  } stage_info_t;

endpackage

// File: rtl/fwd_select.sv
// Per-operand forwarding select: compares one decode read address against the
// EX and MEM shadow destinations and picks the youngest writer.
//   rs_i                   : decode read address
//   uses_i                 : decode instruction actually reads this operand
//   ex_dest_i, ex_wr_i     : EX-stage destination and write enable
//   mem_dest_i, mem_wr_i   : MEM-stage destination and write enable
//   sel_o                  : FWD_RF / FWD_EX / FWD_MEM
module fwd_select
  import haz_pkg::*;
(
  input  logic [RegW-1:0] rs_i,
  input  logic            uses_i,
  input  logic [RegW-1:0] ex_dest_i,
  input  logic            ex_wr_i,
  input  logic [RegW-1:0] mem_dest_i,
  input  logic            mem_wr_i,
  output fwd_sel_t        sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    // XZR reads as zero, so a matching XZR destination must never forward.
    if (uses_i && (rs_i != XZR)) begin
      if (ex_wr_i && (ex_dest_i == rs_i)) begin
        sel_o = FWD_EX;
      end else if (mem_wr_i && (mem_dest_i == rs_i)) begin
        sel_o = FWD_MEM;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and forwarding controller for the 5-stage ARM-subset core.
// Shadows the EX and MEM destinations/controls and produces, combinationally
// from decode inputs:
//   pc_wr_en, ifid_wr_en, id_bubble : load-use stall controls
//   br_taken, ifid_flush            : decode-stage branch redirect and flush
//   fwd_a, fwd_b                    : operand forwarding selects
//   flag_sel                        : B.cond uses live EX flags when set
//   stall_count                     : saturating count of stall cycles
// Synchronous active-low reset (reset). While reset is low every output is
// forced to its reset value.
// Build option: BRANCH_DELAY_SLOT_EN ties ifid_flush to 0 (delay-slot mode).
// REG_W must equal haz_pkg::RegW.
module hazard_ctrl
  import haz_pkg::*;
#(
  parameter int unsigned REG_W = RegW,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rb,
  input  logic             id_uses_rn,
  input  logic             id_uses_rb,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_bl,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_update_flags,
  input  logic             id_is_uncond,
  input  logic             id_is_cbz,
  input  logic             id_is_bcond,
  input  logic             cbz_zero,
  input  logic             cond_true_reg,
  input  logic             cond_true_alu,
  output logic             pc_wr_en,
  output logic             ifid_wr_en,
  output logic             ifid_flush,
  output logic             id_bubble,
  output logic             br_taken,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             flag_sel,
  output logic [CNT_W-1:0] stall_count
);

  logic [RegW-1:0] rn, rb, id_dest;
  stage_info_t     ex_q, ex_d, mem_q, mem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            load_use, stall, flag_sel_raw, br_raw;
  fwd_sel_t        sel_a, sel_b;
  logic            unused_mem_ctrl;

  assign rn      = RegW'(id_rn);
  assign rb      = RegW'(id_rb);
  assign id_dest = id_bl ? LR : RegW'(id_rd);

  // MEM only needs dest/reg_write for forwarding; the rest is carried for visibility.
  assign unused_mem_ctrl = ^{mem_q.mem_read, mem_q.update_flags};

  fwd_select u_fwd_a (
    .rs_i       (rn),
    .uses_i     (id_uses_rn),
    .ex_dest_i  (ex_q.dest),
    .ex_wr_i    (ex_q.reg_write),
    .mem_dest_i (mem_q.dest),
    .mem_wr_i   (mem_q.reg_write),
    .sel_o      (sel_a)
  );

  fwd_select u_fwd_b (
    .rs_i       (rb),
    .uses_i     (id_uses_rb),
    .ex_dest_i  (ex_q.dest),
    .ex_wr_i    (ex_q.reg_write),
    .mem_dest_i (mem_q.dest),
    .mem_wr_i   (mem_q.reg_write),
    .sel_o      (sel_b)
  );

  always_comb begin
    load_use = ex_q.mem_read && ex_q.reg_write && (ex_q.dest != XZR) &&
               ((id_uses_rn && (rn == ex_q.dest)) || (id_uses_rb && (rb == ex_q.dest)));
    // Reset abandons any stall so no bubble or count is recorded.
    stall        = reset && load_use;
    flag_sel_raw = id_is_bcond && ex_q.update_flags;
    br_raw       = id_is_uncond || (id_is_cbz && cbz_zero) ||
                   (id_is_bcond && (flag_sel_raw ? cond_true_alu : cond_true_reg));
  end

  always_comb begin
    pc_wr_en   = !stall;
    ifid_wr_en = !stall;
    id_bubble  = stall;
    // A stalled branch re-evaluates next cycle once its operands are valid.
    br_taken   = reset && !stall && br_raw;
`ifdef BRANCH_DELAY_SLOT_EN
    ifid_flush = 1'b0;
`else
    ifid_flush = br_taken;
`endif
    fwd_a       = reset ? sel_a : FWD_RF;
    fwd_b       = reset ? sel_b : FWD_RF;
    flag_sel    = reset && flag_sel_raw;
    stall_count = reset ? cnt_q : '0;
  end

  always_comb begin
    ex_d.dest         = id_dest;
    ex_d.reg_write    = id_reg_write && !id_bubble;
    ex_d.mem_read     = id_mem_read && !id_bubble;
    ex_d.update_flags = id_update_flags && !id_bubble;
    mem_d             = ex_q;
    cnt_d             = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed instruction sequences, a history-based model
// of the two older in-flight instructions, and a per-cycle output compare.
module tb_hazard_ctrl;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned CNT_W  = 3;
  localparam int          CntMax = (1 << CNT_W) - 1;
`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit DelaySlot = 1'b1;
`else
  localparam bit DelaySlot = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic [REG_W-1:0] id_rn, id_rb, id_rd;
  logic id_uses_rn, id_uses_rb, id_bl, id_reg_write, id_mem_read, id_update_flags;
  logic id_is_uncond, id_is_cbz, id_is_bcond, cbz_zero, cond_true_reg, cond_true_alu;
  logic pc_wr_en, ifid_wr_en, ifid_flush, id_bubble, br_taken, flag_sel;
  logic [1:0] fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_count;

  int n_vec = 0;
  int n_err = 0;

  // Model: index 0 = instruction now in EX, index 1 = instruction now in MEM.
  int m_dest[2];
  bit m_wr[2], m_ld[2], m_fl[2];
  int m_cnt;
  bit m_st;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rn           (id_rn),
    .id_rb           (id_rb),
    .id_uses_rn      (id_uses_rn),
    .id_uses_rb      (id_uses_rb),
    .id_rd           (id_rd),
    .id_bl           (id_bl),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .id_update_flags (id_update_flags),
    .id_is_uncond    (id_is_uncond),
    .id_is_cbz       (id_is_cbz),
    .id_is_bcond     (id_is_bcond),
    .cbz_zero        (cbz_zero),
    .cond_true_reg   (cond_true_reg),
    .cond_true_alu   (cond_true_alu),
    .pc_wr_en        (pc_wr_en),
    .ifid_wr_en      (ifid_wr_en),
    .ifid_flush      (ifid_flush),
    .id_bubble       (id_bubble),
    .br_taken        (br_taken),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .flag_sel        (flag_sel),
    .stall_count     (stall_count)
  );

  function automatic void chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic bit reads(int rs, bit used, int idx);
    return used && m_wr[idx] && (m_dest[idx] != 31) && (m_dest[idx] == rs);
  endfunction

  function automatic bit m_stall();
    return m_ld[0] && (reads(int'(id_rn), id_uses_rn, 0) || reads(int'(id_rb), id_uses_rb, 0));
  endfunction

  // Youngest older writer wins: EX (1) before MEM (2), else register file (0).
  function automatic int m_fwd(int rs, bit used);
    for (int s = 0; s < 2; s++) begin
      if (reads(rs, used, s)) return s + 1;
    end
    return 0;
  endfunction

  function automatic bit m_flagsel();
    return id_is_bcond && m_fl[0];
  endfunction

  function automatic bit m_br();
    if (m_stall()) return 1'b0;
    return id_is_uncond || (id_is_cbz && cbz_zero) ||
           (id_is_bcond && (m_flagsel() ? cond_true_alu : cond_true_reg));
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        m_dest[i] = 0; m_wr[i] = 0; m_ld[i] = 0; m_fl[i] = 0;
      end
      m_cnt = 0;
    end else begin
      m_st = m_stall();
      m_dest[1] = m_dest[0]; m_wr[1] = m_wr[0]; m_ld[1] = m_ld[0]; m_fl[1] = m_fl[0];
      m_dest[0] = id_bl ? 30 : int'(id_rd);
      m_wr[0]   = !m_st && id_reg_write;
      m_ld[0]   = !m_st && id_mem_read;
      m_fl[0]   = !m_st && id_update_flags;
      if (m_st && m_cnt < CntMax) m_cnt++;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("pc_wr_en", int'(pc_wr_en), 1);
      chk("ifid_wr_en", int'(ifid_wr_en), 1);
      chk("ifid_flush", int'(ifid_flush), 0);
      chk("id_bubble", int'(id_bubble), 0);
      chk("br_taken", int'(br_taken), 0);
      chk("fwd_a", int'(fwd_a), 0);
      chk("fwd_b", int'(fwd_b), 0);
      chk("flag_sel", int'(flag_sel), 0);
      chk("stall_count", int'(stall_count), 0);
    end else begin
      chk("pc_wr_en", int'(pc_wr_en), int'(!m_stall()));
      chk("ifid_wr_en", int'(ifid_wr_en), int'(!m_stall()));
      chk("ifid_flush", int'(ifid_flush), int'(m_br() && !DelaySlot));
      chk("id_bubble", int'(id_bubble), int'(m_stall()));
      chk("br_taken", int'(br_taken), int'(m_br()));
      chk("fwd_a", int'(fwd_a), m_fwd(int'(id_rn), id_uses_rn));
      chk("fwd_b", int'(fwd_b), m_fwd(int'(id_rb), id_uses_rb));
      chk("flag_sel", int'(flag_sel), int'(m_flagsel()));
      chk("stall_count", int'(stall_count), m_cnt);
    end
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // Apply a non-branch decode instruction; branch bits cleared.
  task automatic ins(int rd, int rn, int rb, bit urn, bit urb, bit wr, bit ld, bit fl);
    id_rd = REG_W'(rd); id_rn = REG_W'(rn); id_rb = REG_W'(rb);
    id_uses_rn = urn; id_uses_rb = urb;
    id_reg_write = wr; id_mem_read = ld; id_update_flags = fl;
    id_bl = 0; id_is_uncond = 0; id_is_cbz = 0; id_is_bcond = 0;
    cbz_zero = 0; cond_true_reg = 0; cond_true_alu = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    ins(0, 0, 0, 0, 0, 0, 0, 0);
    adv(); adv();
    settle();
    chk("rst_count", int'(stall_count), 0);
    chk("rst_pc", int'(pc_wr_en), 1);
    adv();
    reset = 1'b1;

    // LDUR X1,[X2] ; ADD X2,X1,X3 -> one stall, then MEM forward.
    ins(1, 2, 0, 1, 0, 1, 1, 0); settle(); adv();
    ins(2, 1, 3, 1, 1, 1, 0, 0); settle();
    chk("lu_pc", int'(pc_wr_en), 0);
    chk("lu_ifid", int'(ifid_wr_en), 0);
    chk("lu_bubble", int'(id_bubble), 1);
    adv(); settle();
    chk("lu_count", int'(stall_count), 1);
    chk("lu_fwd_a", int'(fwd_a), 2);
    chk("lu_pc_after", int'(pc_wr_en), 1);
    adv();

    // ADD X5 ; SUB X6,X5,X5 -> EX forward ; reader two later -> MEM forward.
    ins(5, 1, 2, 1, 1, 1, 0, 0); adv();
    ins(6, 5, 5, 1, 1, 1, 0, 0); settle();
    chk("ex_fwd_a", int'(fwd_a), 1);
    chk("ex_fwd_b", int'(fwd_b), 1);
    chk("ex_nostall", int'(id_bubble), 0);
    adv();
    ins(7, 5, 0, 1, 0, 1, 0, 0); settle();
    chk("mem_fwd_a", int'(fwd_a), 2);
    adv();
    // Writers of X5 in both EX and MEM -> EX wins.
    ins(5, 0, 0, 0, 0, 1, 0, 0); adv();
    ins(5, 0, 0, 0, 0, 1, 0, 0); adv();
    ins(8, 5, 0, 1, 0, 1, 0, 0); settle();
    chk("prio_fwd_a", int'(fwd_a), 1);
    adv();

    // XZR never forwards or stalls.
    ins(31, 1, 2, 1, 1, 1, 0, 0); adv();
    ins(9, 31, 31, 1, 1, 1, 0, 0); settle();
    chk("xzr_fwd_a", int'(fwd_a), 0);
    chk("xzr_fwd_b", int'(fwd_b), 0);
    adv();
    ins(31, 1, 0, 1, 0, 1, 1, 0); adv();
    ins(9, 31, 0, 1, 0, 1, 0, 0); settle();
    chk("xzr_ld_pc", int'(pc_wr_en), 1);
    adv();

    // SUBS ; B.EQ using live ALU flags.
    ins(4, 1, 2, 1, 1, 1, 0, 1); adv();
    ins(0, 0, 0, 0, 0, 0, 0, 0);
    id_is_bcond = 1; cond_true_alu = 1; cond_true_reg = 0;
    settle();
    chk("bcond_flag_sel", int'(flag_sel), 1);
    chk("bcond_taken", int'(br_taken), 1);
    chk("bcond_flush", int'(ifid_flush), DelaySlot ? 0 : 1);
    adv();

    // BL ; CBZ X30 with nonzero operand.
    ins(0, 0, 0, 0, 0, 1, 0, 0); id_bl = 1; adv();
    ins(0, 0, 30, 0, 1, 0, 0, 0); id_is_cbz = 1; cbz_zero = 0; settle();
    chk("bl_fwd_b", int'(fwd_b), 1);
    chk("cbz_taken", int'(br_taken), 0);
    adv();

    // LDUR X9 ; CBZ X9 -> stall beats branch, branch resolves next cycle.
    ins(9, 1, 0, 1, 0, 1, 1, 0); adv();
    ins(0, 0, 9, 0, 1, 0, 0, 0); id_is_cbz = 1; cbz_zero = 1; settle();
    chk("sb_taken", int'(br_taken), 0);
    chk("sb_bubble", int'(id_bubble), 1);
    adv(); settle();
    chk("sb_taken2", int'(br_taken), 1);
    chk("sb_fwd_b", int'(fwd_b), 2);
    adv();

    // Back-to-back loads to X3, each consumer stalls once.
    ins(3, 1, 0, 1, 0, 1, 1, 0); adv();
    ins(3, 3, 0, 1, 0, 1, 1, 0); settle();
    chk("bb_bubble1", int'(id_bubble), 1);
    adv(); settle();
    chk("bb_bubble1_end", int'(id_bubble), 0);
    adv();
    ins(10, 3, 3, 1, 1, 1, 0, 0); settle();
    chk("bb_bubble2", int'(id_bubble), 1);
    adv(); settle();
    chk("bb_bubble2_end", int'(id_bubble), 0);
    chk("bb_count", int'(stall_count), 4);
    adv();

    // Drive the 3-bit counter past saturation.
    for (int i = 0; i < 5; i++) begin
      ins(11, 1, 0, 1, 0, 1, 1, 0); adv();
      ins(12, 11, 0, 1, 0, 1, 0, 0); adv(); adv();
    end
    settle();
    chk("sat_count", int'(stall_count), 7);
    adv();

    // Reset asserted during a load-use stall.
    ins(1, 2, 0, 1, 0, 1, 1, 0); adv();
    ins(2, 1, 0, 1, 0, 1, 0, 0); reset = 1'b0; settle();
    chk("rs_pc", int'(pc_wr_en), 1);
    chk("rs_bubble", int'(id_bubble), 0);
    adv();
    reset = 1'b1; settle();
    chk("rs_pc_after", int'(pc_wr_en), 1);
    chk("rs_count_after", int'(stall_count), 0);
    chk("rs_fwd_a_after", int'(fwd_a), 0);
    adv();

    ins(0, 0, 0, 0, 0, 0, 0, 0); adv(); adv();
    settle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and forwarding controller for the 5-stage ARM-subset processor. It sits beside the decode stage and shadows the destination, write and load status of the instructions in EX and MEM. From this it generates load-use stalls, decode-stage branch redirects and flushes, and the operand and flag forwarding selects for the decode-stage forwarding muxes. It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
- REG_W, 5: register-index width.
- CNT_W, 32: stall-counter width.
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- id_rn  in  REG_W  decode first read address (Rn).
- id_rb  in  REG_W  decode second read address, post reg2Loc mux (Rm or Rd).
- id_uses_rn, id_uses_rb  in  1  decode instruction actually reads that operand.
- id_rd  in  REG_W  decode destination.
- id_bl  in  1  decode instruction is BL; the effective destination is X30.
- id_reg_write, id_mem_read, id_update_flags  in  1  decode control bits.
- id_is_uncond, id_is_cbz, id_is_bcond  in  1  branch class in decode.
- cbz_zero  in  1  forwarded second operand equals zero.
- cond_true_reg  in  1  B.cond condition evaluated on architectural flags.
- cond_true_alu  in  1  B.cond condition evaluated on the live EX ALU flags.
- pc_wr_en, ifid_wr_en  out  1  PC and IF/ID write enables.
- ifid_flush  out  1  load NOP into IF/ID at the next edge.
- id_bubble  out  1  zero the controls entering ID/EX.
- br_taken  out  1  redirect PC to the branch target.
- fwd_a, fwd_b  out  2  operand source: 00 register file, 01 EX result, 10 MEM result.
- flag_sel  out  1  1 selects cond_true_alu.
- stall_count  out  CNT_W  total stall cycles since reset.

## Operation
- Effective destination: id_bl ? 30 : id_rd.
- Shadow stages: ex_{dest, reg_write, mem_read, update_flags} load from decode every cycle. If id_bubble=1, all ex_* control bits load 0. mem_* loads from ex_* every cycle.
- X31 (XZR) never matches; a destination of 31 never causes a forward or a stall.
- Load-use stall, when ex_mem_read & ex_reg_write & ex_dest≠31 & ((id_uses_rn & id_rn==ex_dest) | (id_uses_rb & id_rb==ex_dest)):
  - pc_wr_en=0, ifid_wr_en=0, id_bubble=1, br_taken=0, ifid_flush=0.
  - The stall lasts exactly one cycle. The load then sits in MEM and is forwarded by MEM select.
- Forward select per operand (identical logic for a and b):
  - 01 if the operand is used, the EX stage writes, and ex_dest matches.
  - Else 10 if the same holds for the MEM stage.
  - Else 00.
  - EX has priority over MEM.
- flag_sel = id_is_bcond & ex_update_flags.
- br_taken = !stall & (id_is_uncond | (id_is_cbz & cbz_zero) | (id_is_bcond & (flag_sel ? cond_true_alu : cond_true_reg))).
- ifid_flush = br_taken (without delay slot; see Configuration).
- stall_count increments on each stall cycle and saturates at all-ones.

## Timing
- Forward, stall, branch and flush outputs are combinational from decode inputs and registered shadow state, with zero-cycle latency. Shadow state updates on the rising clk edge.
- Reset (reset=0 at an edge) clears all shadow state and stall_count.
- While reset=0, outputs are forced to their reset values:
  - pc_wr_en=1, ifid_wr_en=1.
  - ifid_flush=0, id_bubble=0, br_taken=0.
  - fwd_a=fwd_b=00, flag_sel=0, stall_count=0.
- Reset asserted during a stall cycle: the stall is abandoned and no bubble is recorded.
- Stall and branch in the same cycle: the stall wins. The branch re-evaluates the next cycle with valid operands.
- Back-to-back loads to the same register: each load-use hazard stalls exactly once.
- stall_count at saturation holds its value and does not wrap.

## Configuration
- BRANCH_DELAY_SLOT_EN defined:
  - ifid_flush is tied to 0.
  - The instruction after any branch always executes.
- BRANCH_DELAY_SLOT_EN undefined:
  - ifid_flush = br_taken.
  - One flush cycle per taken branch.

## Structure
- Shared package haz_pkg holds:
  - enum fwd_sel_t {FWD_RF=2'b00, FWD_EX=2'b01, FWD_MEM=2'b10}.
  - Constants XZR=31 and LR=30.
  - Struct stage_info_t {dest, reg_write, mem_read, update_flags} for the shadow stages.
- One sub-module, fwd_select: a per-operand comparator and priority encoder, instantiated twice (operands a and b).

## Test plan
- LDUR X1 then ADD X2,X1,X3 → one cycle with pc_wr_en=0, ifid_wr_en=0, id_bubble=1, stall_count=1. The next cycle gives fwd_a=10.
- ADD X5 then SUB X6,X5,X5 → fwd_a=fwd_b=01, no stall. An instruction two later reading X5 gets 10.
- ADD X31,... then read X31 → fwd=00, no stall. An LDUR to X31 followed by a use → no stall.
- SUBS then B.EQ with cond_true_alu=1, cond_true_reg=0 → flag_sel=1, br_taken=1. ifid_flush=1 without the macro, 0 with it.
- BL then CBZ X30 with cbz_zero=0 → fwd_b=01, br_taken=0.
- Load-use stall with reset=0 at the same edge → all outputs at reset values the next cycle, stall_count=0.
